// File: rtl/day10_pkg.sv
// Shared types, widths and helper functions for the day10 press solver.
package day10_pkg;

    // Bits needed to hold the value n, never less than one bit.
    function automatic int count_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1)) begin
            w++;
        end
        return w;
    endfunction

    localparam int MAX_NUM_LIGHTS    = 16;
    localparam int MAX_NUM_BUTTONS   = 13;
    localparam int MAX_NUM_BUTTONS_W = count_width(MAX_NUM_BUTTONS);
    localparam int MAX_NUM_PRESSES_W = MAX_NUM_BUTTONS_W;
    // One extra bit so the exclusive upper bound 2^MAX_NUM_BUTTONS never wraps.
    localparam int GIDX_W            = MAX_NUM_BUTTONS + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Index of the lowest set bit of the Gray step counter: the button that
    // flips when moving from Gray code (gidx-1) to Gray code (gidx).
    function automatic logic [MAX_NUM_BUTTONS_W-1:0] gray_ctz(input logic [GIDX_W-1:0] gidx);
        logic [MAX_NUM_BUTTONS_W-1:0] idx;
        idx = '0;
        for (int i = GIDX_W - 1; i >= 0; i--) begin
            if (gidx[i]) begin
                idx = MAX_NUM_BUTTONS_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/day10_output_if.sv
// Result bundle carried from the press solver to its consumer.
interface day10_output_if;
    import day10_pkg::*;

    logic [MAX_NUM_PRESSES_W-1:0] min_button_presses;
    logic [MAX_NUM_BUTTONS-1:0]   buttons_to_press;

    modport producer (output min_button_presses, output buttons_to_press);
    modport consumer (input  min_button_presses, input  buttons_to_press);
endinterface

// File: rtl/day10_gray_step.sv
// Selects which button toggles at a Gray step and the lights it flips.
module day10_gray_step
    import day10_pkg::*;
(
    input  logic [GIDX_W-1:0]            gidx,
    input  logic [MAX_NUM_LIGHTS-1:0]    masks [MAX_NUM_BUTTONS],
    output logic [MAX_NUM_BUTTONS_W-1:0] toggle_idx,
    output logic [MAX_NUM_LIGHTS-1:0]    toggle_mask
);

    // Priority-encode the toggling button and mux out its light mask.
    always_comb begin
        toggle_idx  = gray_ctz(gidx);
        toggle_mask = '0;
        for (int i = 0; i < MAX_NUM_BUTTONS; i++) begin
            toggle_mask = (toggle_idx == MAX_NUM_BUTTONS_W'(i)) ? masks[i] : toggle_mask;
        end
    end

endmodule

// File: rtl/day10_press_solver.sv
// Minimum-press solver: loads a target and button masks, walks every button
// subset in Gray order (one subset per cycle) and publishes the cheapest hit.
module day10_press_solver
    import day10_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MAX_NUM_LIGHTS-1:0]    cfg_target,
    input  logic [MAX_NUM_BUTTONS_W-1:0] cfg_num_buttons,
    input  logic                         btn_valid,
    output logic                         btn_ready,
    input  logic [MAX_NUM_LIGHTS-1:0]    btn_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_no_solution,
    day10_output_if.producer             out
);

    localparam int L = MAX_NUM_LIGHTS;
    localparam int B = MAX_NUM_BUTTONS;
    localparam int W = MAX_NUM_BUTTONS_W;
    localparam int P = MAX_NUM_PRESSES_W;

    state_t           state_r, next_state_s;
    logic [L-1:0]     target_r, acc_r;
    logic [L-1:0]     mask_r [B];
    logic [W-1:0]     num_r, load_count_r;
    logic [B-1:0]     set_r, best_set_r;
    logic [P-1:0]     pop_r, best_r;
    logic [GIDX_W-1:0] gidx_r;
    logic             found_r;

    logic             cfg_ready_r, btn_ready_r, out_valid_r, no_sol_r;
    logic [P-1:0]     presses_r;
    logic [B-1:0]     bset_r;

    logic             cfg_ready_nx_s, btn_ready_nx_s, out_valid_nx_s, no_sol_nx_s;
    logic [P-1:0]     presses_nx_s;
    logic [B-1:0]     bset_nx_s;

    logic             cfg_fire_s, btn_fire_s, out_fire_s;
    logic [W-1:0]     n_sat_s;
    logic             load_last_s, search_last_s;
    logic [GIDX_W-1:0] step_gidx_s, gidx_last_s;
    logic [W-1:0]     toggle_idx_s;
    logic [L-1:0]     toggle_mask_s, new_acc_s;
    logic [B-1:0]     onehot_s, new_set_s, new_best_set_s;
    logic             new_bit_s, hit_s, new_found_s;
    logic [P-1:0]     new_pop_s, new_best_s;

    assign cfg_fire_s    = cfg_valid && cfg_ready_r;
    assign btn_fire_s    = btn_valid && btn_ready_r;
    assign out_fire_s    = out_valid_r && out_ready;
    assign n_sat_s       = (cfg_num_buttons > W'(B)) ? W'(B) : cfg_num_buttons;
    assign load_last_s   = (load_count_r == (num_r - W'(1)));
    assign step_gidx_s   = gidx_r + GIDX_W'(1);
    assign gidx_last_s   = (GIDX_W'(1) << num_r) - GIDX_W'(1);
    assign search_last_s = (step_gidx_s == gidx_last_s);

    day10_gray_step u_gray_step (
        .gidx        (step_gidx_s),
        .masks       (mask_r),
        .toggle_idx  (toggle_idx_s),
        .toggle_mask (toggle_mask_s)
    );

    assign onehot_s       = B'(1) << toggle_idx_s;
    assign new_set_s      = set_r ^ onehot_s;
    assign new_bit_s      = |(new_set_s & onehot_s);
    assign new_acc_s      = acc_r ^ toggle_mask_s;
    assign new_pop_s      = new_bit_s ? (pop_r + P'(1)) : (pop_r - P'(1));
    // Strict less-than keeps the earliest Gray-order set on ties.
    assign hit_s          = (new_acc_s == target_r) && (new_pop_s < best_r);
    assign new_best_s     = hit_s ? new_pop_s : best_r;
    assign new_best_set_s = hit_s ? new_set_s : best_set_r;
    assign new_found_s    = found_r || hit_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decision for the solver phases.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_fire_s) begin
                    next_state_s = ((cfg_target == '0) || (n_sat_s == '0)) ? DONE : LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD:    next_state_s = (btn_fire_s && load_last_s) ? SEARCH : LOAD;
            SEARCH:  next_state_s = search_last_s ? DONE : SEARCH;
            DONE:    next_state_s = out_fire_s ? IDLE : DONE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered handshake and result outputs.
    always_comb begin
        cfg_ready_nx_s = (next_state_s == IDLE);
        btn_ready_nx_s = (next_state_s == LOAD);
        out_valid_nx_s = (next_state_s == DONE);
        no_sol_nx_s    = 1'b0;
        presses_nx_s   = '0;
        bset_nx_s      = '0;
        case (state_r)
            IDLE: no_sol_nx_s = cfg_fire_s && (cfg_target != '0) && (n_sat_s == '0);
            LOAD: no_sol_nx_s = 1'b0;
            SEARCH: begin
                no_sol_nx_s  = search_last_s && !new_found_s;
                presses_nx_s = (search_last_s && new_found_s) ? new_best_s : '0;
                bset_nx_s    = (search_last_s && new_found_s) ? new_best_set_s : '0;
            end
            DONE: begin
                no_sol_nx_s  = out_fire_s ? 1'b0 : no_sol_r;
                presses_nx_s = out_fire_s ? '0 : presses_r;
                bset_nx_s    = out_fire_s ? '0 : bset_r;
            end
            default: no_sol_nx_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ready_r <= 1'b1;
            btn_ready_r <= 1'b0;
            out_valid_r <= 1'b0;
            no_sol_r    <= 1'b0;
            presses_r   <= '0;
            bset_r      <= '0;
        end else begin
            cfg_ready_r <= cfg_ready_nx_s;
            btn_ready_r <= btn_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            no_sol_r    <= no_sol_nx_s;
            presses_r   <= presses_nx_s;
            bset_r      <= bset_nx_s;
        end
    end

    // Machine header latch, mask loading and one Gray search step per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_r     <= '0;
            num_r        <= '0;
            load_count_r <= '0;
            acc_r        <= '0;
            set_r        <= '0;
            pop_r        <= '0;
            gidx_r       <= '0;
            best_r       <= '0;
            best_set_r   <= '0;
            found_r      <= 1'b0;
            for (int i = 0; i < B; i++) begin
                mask_r[i] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (cfg_fire_s) begin
                        target_r     <= cfg_target;
                        num_r        <= n_sat_s;
                        load_count_r <= '0;
                        acc_r        <= '0;
                        set_r        <= '0;
                        pop_r        <= '0;
                        gidx_r       <= '0;
                        best_r       <= '0;
                        best_set_r   <= '0;
                        found_r      <= 1'b0;
                        for (int i = 0; i < B; i++) begin
                            mask_r[i] <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (btn_fire_s) begin
                        for (int i = 0; i < B; i++) begin
                            if (load_count_r == W'(i)) begin
                                mask_r[i] <= btn_mask;
                            end
                        end
                        load_count_r <= load_count_r + W'(1);
                        best_r       <= '1;
                        found_r      <= 1'b0;
                    end
                end
                SEARCH: begin
                    gidx_r     <= step_gidx_s;
                    acc_r      <= new_acc_s;
                    set_r      <= new_set_s;
                    pop_r      <= new_pop_s;
                    best_r     <= new_best_s;
                    best_set_r <= new_best_set_s;
                    found_r    <= new_found_s;
                end
                DONE:    found_r <= found_r;
                default: found_r <= 1'b0;
            endcase
        end
    end

    assign cfg_ready              = cfg_ready_r;
    assign btn_ready              = btn_ready_r;
    assign out_valid              = out_valid_r;
    assign out_no_solution        = no_sol_r;
    assign out.min_button_presses = presses_r;
    assign out.buttons_to_press   = bset_r;

endmodule
